mb8_arb: RTL and testbench
==========================

Name: mb8_arb

Overview:
- Arbitrates the single 8-bit, 128 KB byte memory between two requesters.
  - eJ32 core: instruction fetch, data and stack bytes.
  - Host/console DMA: fills TIB and drains OBUF.
- Sits between the requesters and spram8_128k, replacing the direct core-to-memory wiring in the top level.
- Core has priority. A starvation counter and a bounded burst lock guarantee host progress without unbounded core stalls.

Parameters:
- ASZ, 17: byte address width (128 KB).
- STARVE, 8: consecutive denied host-request cycles before host is forced ownership.
- MAX_BURST, 16: maximum host grants per ownership period, lock included.

Ports:
- clk  in  1  system clock; memory samples on the falling edge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  core access request.
- c_we  in  1  core write enable.
- c_addr  in  ASZ  core byte address.
- c_wdata  in  8  core write data.
- c_gnt  out  1  core access performed this cycle.
- c_hold  out  1  core stall, equal to c_req & ~c_gnt.
- c_rdata  out  8  core read data, registered.
- c_rvld  out  1  c_rdata valid.
- h_req  in  1  host access request.
- h_lock  in  1  host requests burst retention.
- h_we  in  1  host write enable.
- h_addr  in  ASZ  host byte address.
- h_wdata  in  8  host write data.
- h_gnt  out  1  host access performed this cycle.
- h_rdata  out  8  host read data, registered.
- h_rvld  out  1  h_rdata valid.
- m_addr  out  ASZ  memory address.
- m_we  out  1  memory write enable.
- m_wdata  out  8  memory write data.
- m_rdata  in  8  memory read data, valid before the next rising edge.
- own_host  out  1  debug: FSM is in OWN_HOST.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - FSM = OWN_CORE; wait_cnt = 0; burst_cnt = 0.
  - c_rvld = h_rvld = 0; c_rdata = h_rdata = 8'h00.
  - Grants follow combinationally from the reset state and the requests.
- FSM state OWN_CORE:
  - c_gnt = c_req.
  - h_gnt = h_req & ~c_req.
  - wait_cnt increments when h_req & ~h_gnt. It clears when h_gnt or ~h_req.
  - When wait_cnt == STARVE-1 and the host is denied again, next state is OWN_HOST, burst_cnt = 0, wait_cnt = 0.
- FSM state OWN_HOST:
  - h_gnt = h_req.
  - c_gnt = 0 (c_hold = c_req). c_gnt stays low even when h_req is low this cycle.
  - burst_cnt increments on each h_gnt.
  - Return to OWN_CORE on the first of:
    - ~h_req;
    - h_gnt & ~h_lock (single access);
    - h_gnt with burst_cnt == MAX_BURST-1.
  - The return is taken at the next edge.
- Memory mux (combinational):
  - Driven by the winning requester.
  - With no grant: m_we = 0, and m_addr/m_wdata follow the core inputs.
  - m_we is never asserted without a grant.
- Read return:
  - A granted read (gnt & ~we) registers m_rdata into the requester's rdata at the next rising edge and pulses rvld for 1 cycle. Latency is 1 cycle.
  - Writes produce no rvld.
- Exactly one of c_gnt/h_gnt may be high in any cycle. This is an assertion.
- Simultaneous first requests: core wins.
- After MAX_BURST the host goes back to OWN_CORE. If the core is idle the host is still served there, one access per cycle.
- A request dropped while denied leaves no state apart from the wait_cnt clear.
- rst mid-burst:
  - Next cycle is OWN_CORE with counters cleared and rvld cleared.
  - Any pending read data is discarded.
- wait_cnt width is clog2(STARVE)+1. It saturates and never wraps.

Decomposition:
- Add to ej32_pkg:
  - arb_state_t enum {OWN_CORE, OWN_HOST};
  - MEM_ASZ = 17.
- Single sub-module mb8_rdret: per-requester read-return register, instantiated twice. Each instance takes gnt, we and m_rdata and produces rdata and rvld.
- The FSM, counters and mux stay in mb8_arb.

Test Plan:
1. Core-only traffic:
   - Stimulus: reads at 0x1000..0x1003 back to back, memory preloaded with 0x41..0x44.
   - Response: c_gnt high every cycle; c_rvld pulses 1 cycle later with 0x41..0x44; h_gnt = 0.
2. Idle-gap host service:
   - Stimulus: host write 0x5A to 0x1400 while c_req = 0.
   - Response: h_gnt in the same cycle, m_we = 1, m_addr = 0x1400; a core read of 0x1400 next cycle returns 0x5A.
3. Starvation:
   - Stimulus: c_req held high, h_req high from cycle 0.
   - Response: h_gnt = 0 for cycles 0..7, own_host in cycle 8 with h_gnt = 1 and c_hold = 1, OWN_CORE again in cycle 9 (h_lock = 0).
4. Burst cap:
   - Stimulus: h_lock = 1 with 20 host reads queued while the core requests continuously.
   - Response: exactly 16 consecutive h_gnt, then c_gnt resumes; no cycle has both grants.
5. Reset mid-burst:
   - Stimulus: rst asserted for 1 cycle at burst_cnt = 5 during a host read.
   - Response: next cycle h_rvld = 0, own_host = 0, and c_gnt follows c_req immediately.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared types and constants for the eJ32 memory subsystem.
package ej32_pkg;

  // Which requester currently owns the byte memory.
  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } arb_state_t;

  // Byte address width of the 128 KB memory.
  localparam int MEM_ASZ = 17;

endpackage

// File: rtl/mb8_rdret.sv
// Per-requester read-return register: captures memory read data one cycle
// after a granted read and flags it with a single-cycle valid pulse.
module mb8_rdret (
  input  logic       clk,
  input  logic       rst,
  input  logic       gnt,
  input  logic       we,
  input  logic [7:0] m_rdata,
  output logic [7:0] rdata,
  output logic       rvld
);

  // Latch read data on a granted read; writes leave rdata untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
      rvld  <= 1'b0;
    end else begin
      rvld <= gnt & ~we;
      if (gnt && !we) rdata <= m_rdata;
    end
  end

endmodule

// File: rtl/mb8_arb.sv
// Two-requester arbiter for the single 8-bit byte memory. The core has
// priority; a starvation counter forces host ownership and a burst cap
// bounds how long the host can hold the memory.
module mb8_arb
  import ej32_pkg::*;
#(
  parameter int ASZ       = MEM_ASZ,
  parameter int STARVE    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           c_req,
  input  logic           c_we,
  input  logic [ASZ-1:0] c_addr,
  input  logic [7:0]     c_wdata,
  output logic           c_gnt,
  output logic           c_hold,
  output logic [7:0]     c_rdata,
  output logic           c_rvld,
  input  logic           h_req,
  input  logic           h_lock,
  input  logic           h_we,
  input  logic [ASZ-1:0] h_addr,
  input  logic [7:0]     h_wdata,
  output logic           h_gnt,
  output logic [7:0]     h_rdata,
  output logic           h_rvld,
  output logic [ASZ-1:0] m_addr,
  output logic           m_we,
  output logic [7:0]     m_wdata,
  input  logic [7:0]     m_rdata,
  output logic           own_host
);

  localparam int WW = $clog2(STARVE) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [WW-1:0] WAIT_LAST  = WW'(STARVE - 1);
  localparam logic [WW-1:0] WAIT_MAX   = {WW{1'b1}};
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  arb_state_t    state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [BW-1:0] burst_cnt, burst_nx;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= OWN_CORE;
      wait_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      burst_cnt <= burst_nx;
    end
  end

  // Grants and next-state: core-first in OWN_CORE, host-only in OWN_HOST.
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    burst_nx = burst_cnt;
    c_gnt    = 1'b0;
    h_gnt    = 1'b0;
    case (state)
      OWN_CORE: begin
        c_gnt = c_req;
        h_gnt = h_req & ~c_req;
        if (h_req && !h_gnt) begin
          if (wait_cnt == WAIT_LAST) begin
            state_nx = OWN_HOST;
            wait_nx  = '0;
            burst_nx = '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_nx = wait_cnt + 1'b1;
          end
        end else begin
          wait_nx = '0;
        end
      end
      OWN_HOST: begin
        h_gnt   = h_req;
        wait_nx = '0;
        if (h_gnt) burst_nx = burst_cnt + 1'b1;
        // Leave on idle host, an unlocked access, or the last allowed grant.
        if (!h_req || (h_gnt && (!h_lock || burst_cnt == BURST_LAST)))
          state_nx = OWN_CORE;
      end
      default: state_nx = OWN_CORE;
    endcase
  end

  // Memory mux: the host drives only when granted; otherwise the core
  // inputs pass through with the write gated by the core grant.
  always_comb begin
    m_addr  = c_addr;
    m_wdata = c_wdata;
    m_we    = c_gnt & c_we;
    if (h_gnt) begin
      m_addr  = h_addr;
      m_wdata = h_wdata;
      m_we    = h_we;
    end
  end

  assign c_hold   = c_req & ~c_gnt;
  assign own_host = (state == OWN_HOST);

  // Grants must be mutually exclusive.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(c_gnt && h_gnt));
  end

  mb8_rdret u_core_ret (
    .clk     (clk),
    .rst     (rst),
    .gnt     (c_gnt),
    .we      (c_we),
    .m_rdata (m_rdata),
    .rdata   (c_rdata),
    .rvld    (c_rvld)
  );

  mb8_rdret u_host_ret (
    .clk     (clk),
    .rst     (rst),
    .gnt     (h_gnt),
    .we      (h_we),
    .m_rdata (m_rdata),
    .rdata   (h_rdata),
    .rvld    (h_rvld)
  );

endmodule

// File: tb/tb_mb8_arb.sv
// Self-checking bench for mb8_arb: directed scenarios followed by random
// traffic, compared cycle by cycle against a behavioural arbiter model.
module tb_mb8_arb;

  localparam int ASZ       = 17;
  localparam int STARVE    = 8;
  localparam int MAX_BURST = 16;
  localparam int MSZ       = 1 << ASZ;

  logic           clk, rst;
  logic           c_req, c_we, c_gnt, c_hold, c_rvld;
  logic [ASZ-1:0] c_addr;
  logic [7:0]     c_wdata, c_rdata;
  logic           h_req, h_lock, h_we, h_gnt, h_rvld;
  logic [ASZ-1:0] h_addr;
  logic [7:0]     h_wdata, h_rdata;
  logic [ASZ-1:0] m_addr;
  logic           m_we;
  logic [7:0]     m_wdata, m_rdata;
  logic           own_host;

  int checks = 0;
  int errors = 0;

  // Memory seen by the DUT, and an independent copy owned by the model.
  logic [7:0] mem     [MSZ];
  logic [7:0] ref_mem [MSZ];

  // Model state.
  bit         m_own;
  int         m_wait, m_burst;
  bit         m_crvld, m_hrvld;
  logic [7:0] m_crdata, m_hrdata;
  bit         obs_hg;

  mb8_arb #(.ASZ(ASZ), .STARVE(STARVE), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_hold(c_hold), .c_rdata(c_rdata), .c_rvld(c_rvld),
    .h_req(h_req), .h_lock(h_lock), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvld(h_rvld),
    .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .own_host(own_host)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte SRAM sampling on the falling edge.
  always @(negedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
    m_rdata <= mem[m_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, then advance the model.
  task automatic cycle();
    bit ec, eh, ewe;
    @(negedge clk); #1;
    if (m_own) begin ec = 1'b0; eh = h_req; end
    else begin ec = c_req; eh = h_req && !c_req; end
    ewe = eh ? h_we : (ec && c_we);
    obs_hg = h_gnt;
    chk("c_gnt", c_gnt, ec);
    chk("h_gnt", h_gnt, eh);
    chk("c_hold", c_hold, c_req && !ec);
    chk("own_host", own_host, m_own);
    chk("one_gnt", c_gnt & h_gnt, 0);
    chk("m_we", m_we, ewe);
    if (ec || eh) chk("m_addr", m_addr, eh ? h_addr : c_addr);
    else          chk("m_addr_idle", m_addr, c_addr);
    if (ewe) chk("m_wdata", m_wdata, eh ? h_wdata : c_wdata);
    chk("c_rvld", c_rvld, m_crvld);
    chk("h_rvld", h_rvld, m_hrvld);
    chk("c_rdata", c_rdata, m_crdata);
    chk("h_rdata", h_rdata, m_hrdata);

    // Read return one cycle later; reset discards it.
    if (rst) begin
      m_crvld = 0; m_hrvld = 0; m_crdata = 8'h00; m_hrdata = 8'h00;
    end else begin
      m_crvld = ec && !c_we;
      m_hrvld = eh && !h_we;
      if (m_crvld) m_crdata = ref_mem[c_addr];
      if (m_hrvld) m_hrdata = ref_mem[h_addr];
    end
    if (ec && c_we) ref_mem[c_addr] = c_wdata;
    if (eh && h_we) ref_mem[h_addr] = h_wdata;

    // Ownership rules.
    if (rst) begin
      m_own = 0; m_wait = 0; m_burst = 0;
    end else if (!m_own) begin
      if (h_req && !eh) begin
        if (m_wait + 1 == STARVE) begin m_own = 1; m_wait = 0; m_burst = 0; end
        else m_wait++;
      end else m_wait = 0;
    end else begin
      if (eh) m_burst++;
      if (!h_req || (eh && !h_lock) || (eh && m_burst == MAX_BURST)) m_own = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    c_req = 0; h_req = 0; h_lock = 0; c_we = 0; h_we = 0;
  endtask

  initial begin
    int first, run, maxrun, served, hcnt;
    for (int i = 0; i < MSZ; i++) begin
      mem[i] = 8'(i ^ (i >> 8));
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem[17'h1000 + i] = 8'h41 + 8'(i);
      ref_mem[17'h1000 + i] = 8'h41 + 8'(i);
    end
    idle();
    c_addr = '0; c_wdata = '0; h_addr = '0; h_wdata = '0;
    m_own = 0; m_wait = 0; m_burst = 0;
    m_crvld = 0; m_hrvld = 0; m_crdata = 8'h00; m_hrdata = 8'h00;
    rst = 1;
    @(posedge clk); #1;
    cycle();            // reset state, still in reset
    rst = 0;

    // 1: core-only back-to-back reads
    for (int i = 0; i < 4; i++) begin
      c_req = 1; c_we = 0; c_addr = 17'h1000 + 17'(i);
      cycle();
    end
    idle(); cycle();
    chk("t1_last_rdata", c_rdata, 8'h44);

    // 2: host write in an idle gap, core reads it back
    h_req = 1; h_we = 1; h_addr = 17'h1400; h_wdata = 8'h5A;
    cycle();
    idle(); c_req = 1; c_addr = 17'h1400;
    cycle();
    idle(); cycle();
    chk("t2_readback", c_rdata, 8'h5A);

    // 3: starvation forces a single host access
    first = -1;
    c_req = 1; c_addr = 17'h1001; h_req = 1; h_lock = 0; h_addr = 17'h1002;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (obs_hg && first < 0) first = i;
    end
    chk("t3_first_hgnt", first, 8);
    idle(); cycle();

    // 4: locked burst capped at MAX_BURST
    run = 0; maxrun = 0; served = 0;
    c_req = 1; h_req = 1; h_lock = 1;
    for (int i = 0; i < 100 && served < 20; i++) begin
      h_addr = 17'h1000 + 17'(served % 4);
      cycle();
      if (obs_hg) begin served++; run++; if (run > maxrun) maxrun = run; end
      else run = 0;
      if (served == 20) h_req = 0;
    end
    chk("t4_served", served, 20);
    chk("t4_maxrun", maxrun, MAX_BURST);
    idle(); cycle();

    // 5: reset mid-burst during a host read
    hcnt = 0;
    c_req = 1; h_req = 1; h_lock = 1; h_addr = 17'h1003;
    for (int i = 0; i < 40 && hcnt < 5; i++) begin
      cycle();
      if (obs_hg) hcnt++;
    end
    chk("t5_reach", hcnt, 5);
    rst = 1;
    cycle();
    rst = 0;
    chk("t5_h_rvld", h_rvld, 0);
    chk("t5_own", own_host, 0);
    chk("t5_c_gnt", c_gnt, c_req);
    cycle();
    idle(); cycle();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      c_req   = ($urandom_range(0, 3) != 0);
      c_we    = ($urandom_range(0, 3) == 0);
      c_addr  = 17'h1000 + 17'($urandom_range(0, 15));
      c_wdata = 8'($urandom);
      h_req   = ($urandom_range(0, 3) != 0);
      h_lock  = ($urandom_range(0, 2) != 0);
      h_we    = ($urandom_range(0, 2) == 0);
      h_addr  = 17'h1000 + 17'($urandom_range(0, 15));
      h_wdata = 8'($urandom);
      cycle();
    end
    rst = 0; idle(); cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
